mem_block_gatherer: RTL and testbench
=====================================

Name: mem_block_gatherer

Overview:
- Load-side front end for the encrypted datapath.
- Walks a word-addressed memory region, issuing two 64-bit loads per cipher block.
- Matches tagged memory responses, which may return out of order, and assembles each 128-bit ciphertext block.
- Sits between the memory bus and the decrypt engine; hands each block downstream over a valid/ready handshake.

Parameters:
- ADDR_BASE, 64'h0, first load address of the sweep
- ADDR_LIMIT, 64'h10000, exclusive end address; the sweep ends once the next load address is >= ADDR_LIMIT
- ADDR_STEP, 4, address increment per accepted load
- BEAT_WIDTH, 64, memory data width; the block is 2*BEAT_WIDTH

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a sweep; ignored unless IDLE
- mem2proc_response  in  4  0 = request not accepted; nonzero = tag assigned to this cycle's request
- mem2proc_data  in  BEAT_WIDTH  response data, qualified by mem2proc_tag
- mem2proc_tag  in  4  0 = no response this cycle; nonzero = tag of the returning load
- proc2mem_command  out  2  BUS_NONE=2'b00 or BUS_LOAD=2'b01; BUS_STORE is never driven
- proc2mem_address  out  64  load address; 0 when command is BUS_NONE
- blk_valid  out  1  assembled block available
- blk_data  out  2*BEAT_WIDTH  {hi beat, lo beat}; lo beat is at the lower address and sits in [BEAT_WIDTH-1:0]
- blk_ready  in  1  downstream accepts the block when blk_valid && blk_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sweep completes
- blk_count  out  16  blocks handed off since the last start; wraps modulo 2^16

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; addr=ADDR_BASE; tag_lo=tag_hi=0; lo_full=hi_full=0
  - all outputs 0; proc2mem_command=BUS_NONE
- Reset mid-sweep: all in-flight responses are dropped. Captured tags are cleared to 0, and tag 0 never matches.
- FSM states: IDLE, REQ_LO, REQ_HI, WAIT, DELIVER, DONE.
- IDLE:
  - On start, clear blk_count and load addr=ADDR_BASE, then go to REQ_LO.
  - start while busy has no effect.
- REQ_LO: drive BUS_LOAD with proc2mem_address=addr; command and address are decoded from the state, so they are valid in the same cycle.
  - If mem2proc_response!=0: tag_lo<=response, addr<=addr+ADDR_STEP, go to REQ_HI.
  - Otherwise stay and re-issue the same address next cycle (retry until accepted).
- REQ_HI: same as REQ_LO but captures tag_hi, then goes to WAIT.
- Response capture (active in REQ_HI, WAIT and the cycle REQ_HI exits):
  - When mem2proc_tag!=0: if it equals tag_lo and !lo_full, store data into lo and set lo_full.
  - Else if it equals tag_hi and !hi_full, store data into hi and set hi_full.
  - Any other tag is ignored.
- Equal tag_lo/tag_hi values are legal: the first matching response fills lo, the second fills hi.
- Memory latency is >1 cycle, so no response can match a tag in the cycle that tag is granted.
- WAIT: go to DELIVER in the cycle after both lo_full and hi_full are set.
- DELIVER:
  - blk_valid=1; blk_data={hi,lo} held stable until the handshake.
  - On handshake: blk_count++, clear lo_full/hi_full and both tags.
  - Then go to DONE if addr>=ADDR_LIMIT, else to REQ_LO.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Single block in flight: no new loads are issued until the current block is accepted. Downstream backpressure stalls the sweep indefinitely without data loss.
- Address arithmetic is unsigned 64-bit with no wrap handling; ADDR_LIMIT must be > ADDR_BASE and a multiple of 2*ADDR_STEP from it.
- Minimum start-to-blk_valid latency with immediate acceptance and 2-cycle memory: 5 cycles.

Decomposition:
- Shared package mem_bus_pkg holds:
  - BUS_NONE, BUS_LOAD and BUS_STORE localparams
  - typedef mem_tag_t (logic [3:0]) and the constant TAG_NONE=4'h0
  - typedef gather_state_e for the FSM enum
- No sub-module: two beat slots plus the FSM form one module, roughly 200 lines.

Test Plan:
- Reset mid-WAIT with tag_lo=3 outstanding; release; memory returns tag 3 -> nothing captured, blk_valid stays 0, outputs 0, state IDLE.
- Basic sweep with ADDR_LIMIT=16: memory accepts immediately with tags 1,2 and returns in order after 2 cycles with data A=64'h1111, B=64'h2222 -> loads at addresses 0,4,8,12; two blocks, first block = {64'h2222,64'h1111}; done pulses once, blk_count=2.
- Out-of-order return: tags 5,6 granted; tag 6 returns first (data 64'hBB), then tag 5 (64'hAA) -> blk_data=128'h00..BB_00..AA.
- Memory stalls: response=0 for 3 cycles in REQ_LO -> address 0 held on proc2mem_address all 4 cycles; addr advances only after the nonzero grant.
- Backpressure: blk_ready=0 for 10 cycles -> blk_data stable, no BUS_LOAD issued, blk_count unchanged; on ready=1 the count increments and REQ_LO resumes at the next address.
- Stray/duplicate tags: tag 9 (unrelated) returns during WAIT, and tag_lo==tag_hi==4 returns twice with C then D -> stray ignored; block = {D,C}; start pulsed during DELIVER is ignored.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus encodings, tag type and gatherer FSM states.
// Imported by the gatherer, its interface and the bench.
package mem_bus_pkg;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    typedef logic [3:0] mem_tag_t;

    localparam mem_tag_t TAG_NONE = 4'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LO,
        S_REQ_HI,
        S_WAIT,
        S_DELIVER,
        S_DONE
    } gather_state_e;

endpackage

// File: rtl/mem_block_gatherer_if.sv
// Memory bus, control and block hand-off signals of the gatherer.
// master = gatherer side, slave = memory/downstream/controller side.
interface mem_block_gatherer_if #(
    parameter int BEAT_WIDTH = 64
);
    import mem_bus_pkg::*;

    logic                    start;
    mem_tag_t                mem2proc_response;
    logic [BEAT_WIDTH-1:0]   mem2proc_data;
    mem_tag_t                mem2proc_tag;
    logic [1:0]              proc2mem_command;
    logic [63:0]             proc2mem_address;
    logic                    blk_valid;
    logic [2*BEAT_WIDTH-1:0] blk_data;
    logic                    blk_ready;
    logic                    busy;
    logic                    done;
    logic [15:0]             blk_count;

    modport master (
        input  start, mem2proc_response, mem2proc_data,
        input  mem2proc_tag, blk_ready,
        output proc2mem_command, proc2mem_address,
        output blk_valid, blk_data, busy, done, blk_count
    );

    modport slave (
        output start, mem2proc_response, mem2proc_data,
        output mem2proc_tag, blk_ready,
        input  proc2mem_command, proc2mem_address,
        input  blk_valid, blk_data, busy, done, blk_count
    );

endinterface

// File: rtl/mem_block_gatherer.sv
// Sweeps a memory region with two tagged loads per block and hands
// each assembled 128-bit block downstream; one block in flight.
module mem_block_gatherer
    import mem_bus_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE  = 64'h0,
    parameter logic [63:0] ADDR_LIMIT = 64'h10000,
    parameter int          ADDR_STEP  = 4,
    parameter int          BEAT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_block_gatherer_if.master io
);

    gather_state_e         state_q, state_d;
    logic [63:0]           addr_q, addr_d;
    mem_tag_t              tag_lo_q, tag_lo_d;
    mem_tag_t              tag_hi_q, tag_hi_d;
    logic [BEAT_WIDTH-1:0] lo_q, lo_d;
    logic [BEAT_WIDTH-1:0] hi_q, hi_d;
    logic                  lo_full_q, lo_full_d;
    logic                  hi_full_q, hi_full_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  cap_en;
    logic                  issuing;

    assign cap_en  = (state_q == S_REQ_HI) || (state_q == S_WAIT);
    assign issuing = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tag_lo_d  = tag_lo_q;
        tag_hi_d  = tag_hi_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        lo_full_d = lo_full_q;
        hi_full_d = hi_full_q;
        cnt_d     = cnt_q;

        // Tag 0 never matches, so cleared slots ignore stale responses.
        if (cap_en && io.mem2proc_tag != TAG_NONE) begin
            if (io.mem2proc_tag == tag_lo_q && !lo_full_q) begin
                lo_d      = io.mem2proc_data;
                lo_full_d = 1'b1;
            end else if (io.mem2proc_tag == tag_hi_q && !hi_full_q) begin
                hi_d      = io.mem2proc_data;
                hi_full_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    cnt_d   = '0;
                    addr_d  = ADDR_BASE;
                    state_d = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (io.mem2proc_response != TAG_NONE) begin
                    tag_lo_d = io.mem2proc_response;
                    addr_d   = addr_q + 64'(ADDR_STEP);
                    state_d  = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (io.mem2proc_response != TAG_NONE) begin
                    tag_hi_d = io.mem2proc_response;
                    addr_d   = addr_q + 64'(ADDR_STEP);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lo_full_q && hi_full_q) begin
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (io.blk_ready) begin
                    cnt_d     = cnt_q + 16'd1;
                    lo_full_d = 1'b0;
                    hi_full_d = 1'b0;
                    tag_lo_d  = TAG_NONE;
                    tag_hi_d  = TAG_NONE;
                    state_d   = (addr_q >= ADDR_LIMIT) ? S_DONE : S_REQ_LO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= ADDR_BASE;
            tag_lo_q  <= TAG_NONE;
            tag_hi_q  <= TAG_NONE;
            lo_q      <= '0;
            hi_q      <= '0;
            lo_full_q <= 1'b0;
            hi_full_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_lo_q  <= tag_lo_d;
            tag_hi_q  <= tag_hi_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            lo_full_q <= lo_full_d;
            hi_full_q <= hi_full_d;
            cnt_q     <= cnt_d;
        end
    end

    assign io.proc2mem_command = issuing ? BUS_LOAD : BUS_NONE;
    assign io.proc2mem_address = issuing ? addr_q : 64'h0;
    assign io.blk_valid        = (state_q == S_DELIVER);
    assign io.blk_data         = io.blk_valid ? {hi_q, lo_q} : '0;
    assign io.busy             = (state_q != S_IDLE);
    assign io.done             = (state_q == S_DONE);
    assign io.blk_count        = cnt_q;

endmodule

// File: tb/tb_mem_block_gatherer.sv
// Directed bench: scripted memory responses, scoreboarded block output.
// Region is 0..16, i.e. two blocks per sweep.
module tb_mem_block_gatherer;
    import mem_bus_pkg::*;

    localparam int BW = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    mem_block_gatherer_if #(.BEAT_WIDTH(BW)) bus ();

    mem_block_gatherer #(
        .ADDR_BASE (64'h0),
        .ADDR_LIMIT(64'h10),
        .ADDR_STEP (4),
        .BEAT_WIDTH(BW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted block is compared in order.
    always @(negedge clock) begin
        if (reset && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL blk_unexpected: got %0h expected none",
                         bus.blk_data);
            end else begin
                chk("blk_data", bus.blk_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(mem_tag_t ta, mem_tag_t tb, logic [63:0] a,
                         int stall);
        for (int i = 0; i < stall; i++) begin
            chk("stall_cmd", 128'(bus.proc2mem_command), 128'(BUS_LOAD));
            chk("stall_addr", 128'(bus.proc2mem_address), 128'(a));
            bus.mem2proc_response = TAG_NONE;
            tick();
        end
        chk("lo_cmd", 128'(bus.proc2mem_command), 128'(BUS_LOAD));
        chk("lo_addr", 128'(bus.proc2mem_address), 128'(a));
        bus.mem2proc_response = ta;
        tick();
        chk("hi_cmd", 128'(bus.proc2mem_command), 128'(BUS_LOAD));
        chk("hi_addr", 128'(bus.proc2mem_address), 128'(a + 64'd4));
        bus.mem2proc_response = tb;
        tick();
        bus.mem2proc_response = TAG_NONE;
        chk("wait_cmd", 128'(bus.proc2mem_command), 128'(BUS_NONE));
    endtask

    task automatic respond(mem_tag_t t, logic [63:0] d);
        bus.mem2proc_tag  = t;
        bus.mem2proc_data = d;
        tick();
        bus.mem2proc_tag  = TAG_NONE;
        bus.mem2proc_data = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.blk_valid && n < 20) begin
            tick();
            n++;
        end
        chk("blk_valid", 128'(bus.blk_valid), 128'(1'b1));
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_busy"}, 128'(bus.busy), 128'(1'b0));
        chk({tag, "_done"}, 128'(bus.done), 128'(1'b0));
        chk({tag, "_valid"}, 128'(bus.blk_valid), 128'(1'b0));
        chk({tag, "_cmd"}, 128'(bus.proc2mem_command), 128'(BUS_NONE));
        chk({tag, "_addr"}, 128'(bus.proc2mem_address), 128'(0));
        chk({tag, "_data"}, bus.blk_data, 128'(0));
    endtask

    initial begin
        int n;
        logic [127:0] held;

        bus.start             = 1'b0;
        bus.mem2proc_response = TAG_NONE;
        bus.mem2proc_tag      = TAG_NONE;
        bus.mem2proc_data     = '0;
        bus.blk_ready         = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check_idle_outputs("rst");
        chk("rst_count", 128'(bus.blk_count), 128'(0));
        reset = 1'b1;
        tick();

        // Reset while waiting on tag 3; its late return must be dropped.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        issue(4'd3, 4'd7, 64'h0, 0);
        chk("mid_busy", 128'(bus.busy), 128'(1'b1));
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        reset = 1'b1;
        respond(4'd3, 64'h3333);
        tick();
        tick();
        check_idle_outputs("postrst");

        // Basic sweep, in-order responses, minimum latency.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        issue(4'd1, 4'd2, 64'h0, 0);
        respond(4'd1, 64'h1111);
        respond(4'd2, 64'h2222);
        exp_q.push_back({64'h2222, 64'h1111});
        wait_valid(n);
        chk("latency", 128'(n), 128'(1));
        tick();
        chk("cnt1", 128'(bus.blk_count), 128'(1));
        issue(4'd1, 4'd2, 64'h8, 0);
        respond(4'd1, 64'h3333);
        respond(4'd2, 64'h4444);
        exp_q.push_back({64'h4444, 64'h3333});
        wait_valid(n);
        tick();
        chk("done_hi", 128'(bus.done), 128'(1'b1));
        chk("done_busy", 128'(bus.busy), 128'(1'b1));
        chk("cnt2", 128'(bus.blk_count), 128'(2));
        tick();
        chk("done_lo", 128'(bus.done), 128'(1'b0));
        chk("idle_busy", 128'(bus.busy), 128'(1'b0));
        chk("cnt2_hold", 128'(bus.blk_count), 128'(2));

        // Stall, out-of-order return, backpressure, ignored start.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("cnt_clr", 128'(bus.blk_count), 128'(0));
        issue(4'd5, 4'd6, 64'h0, 3);
        respond(4'd6, 64'hBB);
        respond(4'd5, 64'hAA);
        exp_q.push_back({64'hBB, 64'hAA});
        bus.blk_ready = 1'b0;
        wait_valid(n);
        held = bus.blk_data;
        chk("ooo_data", held, {64'hBB, 64'hAA});
        for (int i = 0; i < 10; i++) begin
            chk("bp_data", bus.blk_data, held);
            chk("bp_valid", 128'(bus.blk_valid), 128'(1'b1));
            chk("bp_cmd", 128'(bus.proc2mem_command), 128'(BUS_NONE));
            chk("bp_cnt", 128'(bus.blk_count), 128'(0));
            bus.start = (i == 3);
            tick();
        end
        bus.start     = 1'b0;
        bus.blk_ready = 1'b1;
        tick();
        chk("bp_cnt_inc", 128'(bus.blk_count), 128'(1));

        // Stray tag 9 plus duplicated tag 4 on both beats.
        issue(4'd4, 4'd4, 64'h8, 0);
        respond(4'd9, 64'hDEAD);
        respond(4'd4, 64'hC0C0);
        respond(4'd4, 64'hD0D0);
        exp_q.push_back({64'hD0D0, 64'hC0C0});
        wait_valid(n);
        tick();
        chk("done2_hi", 128'(bus.done), 128'(1'b1));
        chk("cnt_end", 128'(bus.blk_count), 128'(2));
        tick();
        chk("done2_lo", 128'(bus.done), 128'(1'b0));
        chk("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
